// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM state type for the instruction-memory loader.
// Defaults are shared with the instruction memory itself.
package imem_loader_pkg;

  localparam int IMEM_DATA_W    = 32;
  localparam int IMEM_DEPTH     = 32;
  localparam int IMEM_ADDR_W    = 5;
  localparam int BYTES_PER_WORD = IMEM_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Byte counter plus little-endian shift register; the first byte of a word
// ends up in bits [7:0]. word is valid while word_complete is high.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_in,
  output logic              word_complete,
  output logic [DATA_W-1:0] word
);

  localparam int BPW   = DATA_W / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] sr;

  // New bytes enter at the top so that after BPW shifts byte 0 sits lowest.
  assign word          = {byte_in, sr[DATA_W-1:8]};
  assign word_complete = accept && (cnt == CNT_W'(BPW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sr  <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (accept) begin
      sr  <= word;
      cnt <= word_complete ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory writer: packs a byte stream into words and writes them
// at addresses 0..N-1 while holding the CPU. Optional: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W,
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, last_idx;
  logic [ADDR_W:0]   num_sat;
  logic              accept, word_complete, last_word, abort_act;
  logic [DATA_W-1:0] pk_word;

  assign num_sat   = (num_words > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : num_words;
  assign accept    = byte_valid & byte_ready;
  assign last_word = (idx == last_idx);
  assign abort_act = abort && (state == COLLECT || state == WRITE || state == CHECK);
  assign busy      = (state != IDLE);
  assign cpu_hold  = busy;

  imem_loader_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (state == IDLE),
    .accept        (accept),
    .byte_in       (byte_in),
    .word_complete (word_complete),
    .word          (pk_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_words != '0) state_nxt = COLLECT;
`ifdef IMEM_LOADER_CHECKSUM_EN
          else                 state_nxt = CHECK;
`else
          else                 state_nxt = DONE;
`endif
        end
      end
      COLLECT: begin
        byte_ready = 1'b1;
        if (abort)              state_nxt = IDLE;
        else if (word_complete) state_nxt = WRITE;
      end
      WRITE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          wr_en = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = last_word ? CHECK : COLLECT;
`else
          state_nxt = last_word ? DONE : COLLECT;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        if (abort)              state_nxt = IDLE;
        else if (word_complete) state_nxt = DONE;
      end
`endif
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      last_idx <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      if (state == IDLE && start) begin
        idx      <= '0;
        last_idx <= ADDR_W'(num_sat - (ADDR_W+1)'(1));
        err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end
      if (abort_act) err <= 1'b1;
      // Word output registers only move when a word is completed, so they
      // hold their last value everywhere outside WRITE.
      if (state == COLLECT && word_complete && !abort) begin
        wr_addr <= idx;
        wr_data <= pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum    <= csum ^ pk_word;
`endif
      end
      if (state == WRITE && !abort && !last_word) idx <= idx + ADDR_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state == CHECK && word_complete && !abort) err <= (pk_word != csum);
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are
// driven and popped when wr_en is observed.
module tb_imem_loader;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CK_CYC = 4;
`else
  localparam int CK_CYC = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, start, abort, byte_valid;
  logic [ADDR_W:0]   num_words;
  logic [7:0]        byte_in;
  logic              byte_ready, wr_en, cpu_hold, busy, done, err;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .abort(abort), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wr_cnt = 0, done_cnt = 0;
  int last_wr_cyc = 0, acc_cyc = 0, start_cyc = 0, done_cyc = 0;
  logic [ADDR_W-1:0] last_wr_addr;
  bit chk_ready = 1'b0;
  logic [ADDR_W+DATA_W-1:0] sb[$];
  logic [31:0] words [0:63];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs sampled on the falling edge, inputs change after rising.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        logic [ADDR_W+DATA_W-1:0] e;
        wr_cnt++;
        last_wr_cyc  = cyc;
        last_wr_addr = wr_addr;
        if (sb.size() == 0) begin
          check("unexpected_write", {27'd0, wr_addr, wr_data}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("wr_addr", 64'(wr_addr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
          check("wr_data", 64'(wr_data), 64'(e[DATA_W-1:0]));
        end
      end
      if (done) done_cnt++;
      if (chk_ready && busy) check("byte_ready_pattern", 64'(byte_ready), 64'(!(wr_en || done)));
    end
  end

  task automatic start_load(input int n);
    start = 1'b1;
    num_words = (ADDR_W+1)'(n);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_busy_after_start", {62'd0, cpu_hold, busy}, 64'd3);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_in = b;
    byte_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (byte_ready) begin
        acc_cyc = cyc;
        break;
      end
      n++;
      if (n > 50) begin
        check("byte_ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    int n = 0;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cyc = cyc;
        check("hold_at_done", 64'(cpu_hold), 64'd1);
        break;
      end
      n++;
      if (n > 400) begin
        check("done_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    check("idle_after_done", {62'd0, cpu_hold, busy}, 64'd0);
  endtask

  task automatic load(input int n_req, input bit stall, input bit use_ovr, input logic [31:0] ovr);
    int n_act = (n_req > 32) ? 32 : n_req;
    int w0 = wr_cnt;
    int last_acc = 0;
    logic [31:0] x = 32'd0;
    logic [31:0] ck;
    logic [4:0] a;
    bit exp_err = 1'b0;
    start_load(n_req);
    for (int i = 0; i < n_act; i++) begin
      a = i[4:0];
      sb.push_back({a, words[i]});
      x ^= words[i];
      for (int k = 0; k < 4; k++) begin
        if (stall) begin
          byte_valid = 1'b0;
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        send_byte(words[i][8*k +: 8]);
      end
      last_acc = acc_cyc;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    ck = use_ovr ? ovr : x;
    exp_err = (ck != x);
    for (int k = 0; k < 4; k++) send_byte(ck[8*k +: 8]);
`else
    ck = ovr;
    exp_err = use_ovr && 1'b0;
`endif
    byte_valid = 1'b0;
    wait_done();
    check("write_count", 64'(wr_cnt - w0), 64'(n_act));
    check("err_at_end", 64'(err), 64'(exp_err));
    check("sb_drained", 64'(sb.size()), 64'd0);
    if (n_act > 0) begin
      check("wr_latency", 64'(last_wr_cyc), 64'(last_acc + 1));
      check("last_addr", 64'(last_wr_addr), 64'(n_act - 1));
    end
    if (!stall) check("done_cycle", 64'(done_cyc), 64'(start_cyc + 5 * n_act + 1 + CK_CYC));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
    num_words = '0; byte_in = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {58'd0, byte_ready, wr_en, cpu_hold, busy, done, err}, 64'd0);
    check("reset_addr", 64'(wr_addr), 64'd0);
    check("reset_data", 64'(wr_data), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word
    words[0] = 32'h0010_0013;
    load(1, 1'b0, 1'b0, 32'd0);
    check("wr_data_holds", 64'(wr_data), 64'h0010_0013);

    // Three words back to back, byte_valid held high
    words[0] = 32'h0010_0093; words[1] = 32'h0000_8133; words[2] = 32'h0020_A023;
    chk_ready = 1'b1;
    load(3, 1'b0, 1'b0, 32'd0);
    chk_ready = 1'b0;

    // Same words with random stream gaps
    load(3, 1'b1, 1'b0, 32'd0);

    // Saturation: 40 requested, 32 written
    for (int i = 0; i < 32; i++) words[i] = $urandom;
    load(40, 1'b0, 1'b0, 32'd0);

    // Empty load
    load(0, 1'b0, 1'b0, 32'd0);

    // Abort after two bytes of word 1
    words[0] = 32'hA5A5_0001; words[1] = 32'h5A5A_0002; words[2] = 32'h1234_5678;
    w0 = wr_cnt; d0 = done_cnt;
    start_load(3);
    sb.push_back({5'd0, words[0]});
    for (int k = 0; k < 4; k++) send_byte(words[0][8*k +: 8]);
    for (int k = 0; k < 2; k++) send_byte(words[1][8*k +: 8]);
    byte_valid = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_collect_idle", {61'd0, busy, cpu_hold, err}, 64'd1);
    repeat (6) @(posedge clk); #1;
    check("abort_collect_writes", 64'(wr_cnt - w0), 64'd1);
    check("abort_collect_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_collect_sb", 64'(sb.size()), 64'd0);

    // Abort landing in the WRITE cycle suppresses the strobe
    w0 = wr_cnt;
    start_load(2);
    check("err_cleared_on_start", 64'(err), 64'd0);
    for (int k = 0; k < 4; k++) send_byte(words[2][8*k +: 8]);
    byte_valid = 1'b0; abort = 1'b1;
    @(negedge clk);
    check("abort_write_strobe", 64'(wr_en), 64'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_write_idle", {61'd0, busy, cpu_hold, err}, 64'd1);
    repeat (3) @(posedge clk); #1;
    check("abort_write_writes", 64'(wr_cnt - w0), 64'd0);

    // Recovery after abort clears err
    words[0] = 32'hDEAD_BEEF;
    load(1, 1'b0, 1'b0, 32'd0);

    // Reset after six bytes
    w0 = wr_cnt;
    words[0] = 32'h0BAD_F00D; words[1] = 32'hCAFE_0042;
    start_load(2);
    sb.push_back({5'd0, words[0]});
    for (int k = 0; k < 4; k++) send_byte(words[0][8*k +: 8]);
    for (int k = 0; k < 2; k++) send_byte(words[1][8*k +: 8]);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset_ctrl", {58'd0, byte_ready, wr_en, cpu_hold, busy, done, err}, 64'd0);
    check("midreset_addr_data", {27'd0, wr_addr, wr_data}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("midreset_writes", 64'(wr_cnt - w0), 64'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    words[0] = 32'h1111_1111; words[1] = 32'h2222_2222;
    load(2, 1'b0, 1'b1, 32'h3333_3333);
    load(2, 1'b0, 1'b1, 32'h3333_3334);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory.
- Accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instruction words, and issues one-cycle write strobes into the instruction memory at word addresses 0, 1, 2, ...
- Holds the CPU (cpu_hold) for the whole load so fetch never sees a partially written program.

Parameters:
- DATA_W, 32, instruction word width; must be a multiple of 8.
- DEPTH, 32, instruction memory depth in words.
- ADDR_W, 5, word-address width; equals clog2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- num_words  input  ADDR_W+1  number of words to load; latched on accepted start.
- abort  input  1  synchronous cancel of a load in progress.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction memory write strobe, one cycle per word.
- wr_addr  output  ADDR_W  word address for the write.
- wr_data  output  DATA_W  assembled instruction word.
- cpu_hold  output  1  CPU stall/reset request while loading.
- busy  output  1  high when not in IDLE.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  sticky error flag; cleared on the next accepted start.

Behaviour:
- Reset (rst_n low, async): state IDLE. byte_ready, wr_en, cpu_hold, busy, done and err are 0; wr_addr=0; wr_data=0. Word index, byte counter and partial word are cleared. Reset mid-load discards the partial word; no write is issued.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE -> COLLECT on start=1 when num_words != 0.
  - num_words is latched, saturated to DEPTH if larger.
  - Word index and byte counter are set to 0; err is cleared.
  - cpu_hold and busy go high on the next cycle.
- IDLE -> DONE on start=1 with num_words == 0. No writes occur.
- COLLECT:
  - byte_ready=1.
  - A byte is accepted when byte_valid & byte_ready. Byte k (k=0..3) is placed in wr_data[8k+7:8k].
  - byte_valid low: hold state; no timeout.
  - On acceptance of byte 3 -> WRITE.
- WRITE (exactly one cycle):
  - byte_ready=0, wr_en=1, wr_addr=word index, wr_data=assembled word.
  - Next state: DONE if word index == latched count - 1; otherwise increment index, clear byte counter, go to COLLECT.
  - Latency: fourth byte accepted on cycle N -> wr_en on cycle N+1.
  - Back-to-back: the first byte of the next word can be accepted on cycle N+2.
- DONE (one cycle): done=1, cpu_hold=1, byte_ready=0. Then -> IDLE with cpu_hold=0 and busy=0.
- abort=1 in COLLECT or WRITE:
  - Next state is IDLE and any WRITE-state strobe that cycle is suppressed.
  - err=1, done is not pulsed, cpu_hold drops the following cycle.
  - Words already written remain in memory.
- start while busy is ignored. abort in IDLE or DONE is ignored. abort and start together in IDLE: start wins.
- wr_data and wr_addr hold their last values outside WRITE; consumers qualify on wr_en only.
- Word index never wraps, because saturation guarantees index <= DEPTH-1.

Optional Feature:
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last word's WRITE, the FSM enters CHECK instead of DONE.
  - CHECK collects 4 more bytes (same handshake, little-endian) as an expected checksum.
  - The checksum is the 32-bit XOR of all loaded words.
  - Match -> DONE with err=0. Mismatch -> DONE with err=1; done still pulses.
  - The num_words==0 path expects the checksum 0x00000000.
- Not defined: no CHECK state; behaviour exactly as above and err is set only by abort.

Decomposition:
- Shared package holds:
  - The state enum (IDLE, COLLECT, WRITE, CHECK, DONE).
  - BYTES_PER_WORD = DATA_W/8.
  - Default DATA_W, DEPTH and ADDR_W constants, shared with the instruction memory.
- One natural sub-module, byte_packer: byte counter plus little-endian shift/assemble register. It reports word_complete and exposes the word and a clear input.
- The FSM, index counter and optional checksum stay in imem_loader.

Test Plan:
- Single word: start, num_words=1; bytes 0x13,0x00,0x10,0x00 -> one wr_en, wr_addr=0, wr_data=0x00100013; done pulses one cycle after the write; cpu_hold high from cycle after start through done.
- Three words, byte_valid held high: words 0x00100093, 0x00008133, 0x0020A023 -> writes at addresses 0, 1, 2 in order; byte_ready low only in WRITE/DONE cycles; exactly 3 wr_en pulses.
- Stalled stream: byte_valid toggled with random gaps -> identical writes and data as the unstalled case; no extra wr_en.
- Saturation / empty: num_words=40 -> 32 writes, last at wr_addr=31, then done. num_words=0 -> done next cycle with no wr_en.
- Abort and reset mid-load: abort after 2 bytes of word 1 -> no write for word 1, err=1, no done, busy=0 within 2 cycles. rst_n low after 6 bytes -> all outputs 0 immediately.
- Checksum (macro on): words 0x11111111 and 0x22222222 with checksum 0x33333333 -> err=0; same words with checksum 0x33333334 -> err=1, done still pulses.
